// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the issue stage, the
// muldiv_unit execute back end and the writeback stage.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            inValid;
  logic            inReady;
  logic [2:0]      command;
  logic            isWord;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            outValid;
  logic            outReady;
  logic [XLEN-1:0] result;

  modport master (
    output flush, inValid, command, isWord, src1, src2, outReady,
    input  inReady, outValid, result
  );

  modport slave (
    input  flush, inValid, command, isWord, src1, src2, outReady,
    output inReady, outValid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV M-extension multiply/divide unit (XLEN 32 or 64, RV64 W forms).
// Optional macro MULDIV_FAST_MUL_EN: multiply ops use a single-cycle combinational multiplier.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rstN,
  muldiv_unit_if.slave bus
);
  localparam int              CW        = $clog2(XLEN);
  localparam logic [2:0]      CmdMul    = 3'd0;
  localparam logic [2:0]      CmdMulh   = 3'd1;
  localparam logic [2:0]      CmdMulhsu = 3'd2;
  localparam logic [2:0]      CmdDiv    = 3'd4;
  localparam logic [2:0]      CmdRem    = 3'd6;
  localparam logic [XLEN-1:0] WordMask  = XLEN'(64'h0000_0000_FFFF_FFFF);

  typedef enum logic [1:0] {Idle = 2'd0, Run = 2'd1, Done = 2'd2} state_t;

  state_t          stateR, nextStateS;
  logic [CW-1:0]   cntR;
  logic [2:0]      cmdR;
  logic            wordR, negQR, negRR;
  logic [XLEN-1:0] opBR, accHiR, accLoR, resultR;

  // Bit 31 sign-extends W results; full-width results pass through.
  function automatic logic [XLEN-1:0] fmtRes(input logic [XLEN-1:0] v, input logic w);
    if (w && v[31]) return (v & WordMask) | ~WordMask;
    else if (w)     return v & WordMask;
    else            return v;
  endfunction

  // prod holds the unsigned 2N-bit product in its low bits.
  function automatic logic [XLEN-1:0] mulRes(input logic [2*XLEN-1:0] prod, input logic neg,
                                             input logic [2:0] cmd, input logic w);
    logic [2*XLEN-1:0] p;
    p = neg ? (~prod + (2*XLEN)'(1)) : prod;
    if (cmd == CmdMul) return fmtRes(p[XLEN-1:0], w);
    else if (w)        return fmtRes(XLEN'(p[63:32]), w);
    else               return p[2*XLEN-1:XLEN];
  endfunction

  logic            wordS, isDivS, isRemS, sgn1S, sgn2S, neg1S, neg2S;
  logic            divZeroS, ovfS, specialS, fastS, acceptS, lastS, borrowS;
  logic [XLEN-1:0] maskS, minS, mag1S, mag2S, specResS, fastResS, nextHiS, nextLoS, iterResS;
  logic [XLEN:0]   mulSumS, divShS, divDiffS;
  logic [2*XLEN-1:0] prodS, prodAlS;

  assign bus.inReady  = (stateR == Idle);
  assign bus.outValid = (stateR == Done);
  assign bus.result   = resultR;

  // Request decode: operating width, operand magnitudes, signs and special cases.
  always_comb begin
    wordS   = (XLEN == 64) && bus.isWord;
    isDivS  = bus.command[2];
    isRemS  = bus.command[1];
    maskS   = wordS ? WordMask : '1;
    minS    = wordS ? XLEN'(64'h0000_0000_8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    sgn1S   = (bus.command == CmdMulh) || (bus.command == CmdMulhsu) ||
              (bus.command == CmdDiv)  || (bus.command == CmdRem);
    sgn2S   = (bus.command == CmdMulh) || (bus.command == CmdDiv) || (bus.command == CmdRem);
    neg1S   = sgn1S && (wordS ? bus.src1[31] : bus.src1[XLEN-1]);
    neg2S   = sgn2S && (wordS ? bus.src2[31] : bus.src2[XLEN-1]);
    mag1S   = neg1S ? ((~bus.src1 + XLEN'(1)) & maskS) : (bus.src1 & maskS);
    mag2S   = neg2S ? ((~bus.src2 + XLEN'(1)) & maskS) : (bus.src2 & maskS);
    divZeroS = isDivS && ((bus.src2 & maskS) == '0);
    ovfS     = isDivS && !bus.command[0] && ((bus.src1 & maskS) == minS) &&
               ((bus.src2 & maskS) == maskS);
    specialS = divZeroS || ovfS;
    acceptS  = bus.inValid && (stateR == Idle) && !bus.flush;
    if (divZeroS)  specResS = isRemS ? fmtRes(bus.src1, wordS) : '1;
    else if (ovfS) specResS = isRemS ? '0 : fmtRes(bus.src1, wordS);
    else           specResS = '0;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fastProdS;
  assign fastS     = ~bus.command[2];
  assign fastProdS = {{XLEN{1'b0}}, mag1S} * {{XLEN{1'b0}}, mag2S};
  assign fastResS  = mulRes(fastProdS, neg1S ^ neg2S, bus.command, wordS);
`else
  assign fastS    = 1'b0;
  assign fastResS = '0;
`endif

  // One shift-add or restoring-divide step, plus the final result taken from that step.
  always_comb begin
    lastS    = (cntR == (wordR ? CW'(31) : CW'(XLEN-1)));
    mulSumS  = {1'b0, accHiR} + (accLoR[0] ? {1'b0, opBR} : '0);
    divShS   = {accHiR, accLoR[XLEN-1]};
    divDiffS = divShS - {1'b0, opBR};
    borrowS  = divDiffS[XLEN];
    if (cmdR[2]) begin
      nextHiS = borrowS ? divShS[XLEN-1:0] : divDiffS[XLEN-1:0];
      nextLoS = {accLoR[XLEN-2:0], ~borrowS};
    end else begin
      nextHiS = mulSumS[XLEN:1];
      nextLoS = {mulSumS[0], accLoR[XLEN-1:1]};
    end
    // A 32-step W multiply leaves the product 32 bits above its final position.
    prodS   = {nextHiS, nextLoS};
    prodAlS = wordR ? (prodS >> (XLEN-32)) : prodS;
    if (cmdR[2] && cmdR[1])  iterResS = fmtRes(negRR ? (~nextHiS + XLEN'(1)) : nextHiS, wordR);
    else if (cmdR[2])        iterResS = fmtRes(negQR ? (~nextLoS + XLEN'(1)) : nextLoS, wordR);
    else                     iterResS = mulRes(prodAlS, negQR, cmdR, wordR);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) stateR <= Idle;
    else       stateR <= nextStateS;
  end

  // FSM next state; flush overrides every state, including a same-cycle request.
  always_comb begin
    nextStateS = stateR;
    if (bus.flush) begin
      nextStateS = Idle;
    end else begin
      case (stateR)
        Idle:    nextStateS = acceptS ? ((specialS || fastS) ? Done : Run) : Idle;
        Run:     nextStateS = lastS ? Done : Run;
        Done:    nextStateS = bus.outReady ? Idle : Done;
        default: nextStateS = Idle;
      endcase
    end
  end

  // Operand capture on accept, iteration in Run, result register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cntR    <= '0;
      cmdR    <= 3'd0;
      wordR   <= 1'b0;
      negQR   <= 1'b0;
      negRR   <= 1'b0;
      opBR    <= '0;
      accHiR  <= '0;
      accLoR  <= '0;
      resultR <= '0;
    end else begin
      case (stateR)
        Idle: begin
          if (acceptS) begin
            cntR   <= '0;
            cmdR   <= bus.command;
            wordR  <= wordS;
            negQR  <= neg1S ^ neg2S;
            negRR  <= neg1S;
            accHiR <= '0;
            opBR   <= isDivS ? mag2S : mag1S;
            // Dividend is left-aligned so its top bit is shifted in first.
            accLoR <= isDivS ? (wordS ? (mag1S << (XLEN-32)) : mag1S) : mag2S;
            if (specialS)   resultR <= specResS;
            else if (fastS) resultR <= fastResS;
          end
        end
        Run: begin
          accHiR <= nextHiS;
          accLoR <= nextLoS;
          cntR   <= cntR + CW'(1);
          if (lastS) resultR <= iterResS;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench driving an XLEN=32 and an XLEN=64 muldiv_unit.
// Latency is the number of clock edges after the accept edge until outValid is seen.
module tb_muldiv_unit;
  localparam logic [2:0] CmdMul = 3'd0, CmdMulh = 3'd1, CmdMulhsu = 3'd2, CmdMulhu = 3'd3;
  localparam logic [2:0] CmdDiv = 3'd4, CmdDivu = 3'd5, CmdRem = 3'd6, CmdRemu = 3'd7;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sbEntry_t;

  logic clk = 1'b0;
  logic rstN;
  int   assertCount = 0;
  int   failCount = 0;
  sbEntry_t sb32[$];
  sbEntry_t sb64[$];

  muldiv_unit_if #(.XLEN(32)) if32();
  muldiv_unit_if #(.XLEN(64)) if64();

  muldiv_unit #(.XLEN(32)) dut32 (.clk(clk), .rstN(rstN), .bus(if32));
  muldiv_unit #(.XLEN(64)) dut64 (.clk(clk), .rstN(rstN), .bus(if64));

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int mulLat(input int n);
`ifdef MULDIV_FAST_MUL_EN
    return 0 * n;
`else
    return n;
`endif
  endfunction

  function automatic logic obsValid(input bit is64);
    return is64 ? if64.outValid : if32.outValid;
  endfunction

  function automatic logic obsReady(input bit is64);
    return is64 ? if64.inReady : if32.inReady;
  endfunction

  function automatic logic [63:0] obsResult(input bit is64);
    return is64 ? if64.result : {32'h0, if32.result};
  endfunction

  task automatic drive(input bit is64, input logic v, input logic [2:0] c, input logic w,
                       input logic [63:0] a, input logic [63:0] b);
    if (is64) begin
      if64.inValid = v; if64.command = c; if64.isWord = w; if64.src1 = a; if64.src2 = b;
    end else begin
      if32.inValid = v; if32.command = c; if32.isWord = 1'b0; if32.src1 = a[31:0]; if32.src2 = b[31:0];
    end
  endtask

  task automatic setOutReady(input bit is64, input logic v);
    if (is64) if64.outReady = v;
    else      if32.outReady = v;
  endtask

  // Issue one op, check its latency, optionally stall the result, then check the return to Idle.
  task automatic runOp(input bit is64, input logic [2:0] c, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int expLat,
                       input int hold, input string tag);
    int edges;
    setOutReady(is64, hold == 0);
    @(negedge clk);
    checkVal({tag, "_inReady"}, 64'(obsReady(is64)), 64'd1);
    drive(is64, 1'b1, c, w, a, b);
    if (is64) sb64.push_back('{tag, exp});
    else      sb32.push_back('{tag, exp});
    @(posedge clk); #1;
    drive(is64, 1'b0, c, w, a, b);
    edges = 0;
    while (!obsValid(is64) && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    checkVal({tag, "_lat"}, 64'(edges), 64'(expLat));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        checkVal({tag, "_holdValid"}, 64'(obsValid(is64)), 64'd1);
        checkVal({tag, "_holdResult"}, obsResult(is64), exp);
      end
      setOutReady(is64, 1'b1);
    end
    @(posedge clk); #1;
    checkVal({tag, "_idle"}, 64'(obsReady(is64)), 64'd1);
  endtask

  // Scoreboard pop for the 32-bit unit: a transfer happens on the next edge.
  always @(negedge clk) begin
    sbEntry_t e;
    if (rstN && if32.outValid && if32.outReady) begin
      if (sb32.size() == 0) checkVal("spurious32", 64'(if32.outValid), 64'd0);
      else begin
        e = sb32.pop_front();
        checkVal(e.tag, {32'h0, if32.result}, e.exp);
      end
    end
  end

  // Scoreboard pop for the 64-bit unit.
  always @(negedge clk) begin
    sbEntry_t e;
    if (rstN && if64.outValid && if64.outReady) begin
      if (sb64.size() == 0) checkVal("spurious64", 64'(if64.outValid), 64'd0);
      else begin
        e = sb64.pop_front();
        checkVal(e.tag, if64.result, e.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstN = 1'b0;
    if32.flush = 1'b0; if64.flush = 1'b0;
    drive(1'b0, 1'b0, CmdMul, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, CmdMul, 1'b0, 64'd0, 64'd0);
    setOutReady(1'b0, 1'b1);
    setOutReady(1'b1, 1'b1);
    #12;
    checkVal("rst_inReady32", 64'(if32.inReady), 64'd1);
    checkVal("rst_outValid32", 64'(if32.outValid), 64'd0);
    checkVal("rst_result32", {32'h0, if32.result}, 64'd0);
    checkVal("rst_outValid64", 64'(if64.outValid), 64'd0);
    checkVal("rst_result64", if64.result, 64'd0);
    @(negedge clk);
    rstN = 1'b1;

    // XLEN=32 ops
    runOp(1'b0, CmdMul,    1'b0, 64'd7,          64'hFFFF_FFFD, 64'hFFFF_FFEB, mulLat(32), 0, "mul32");
    runOp(1'b0, CmdMulh,   1'b0, 64'h8000_0000,  64'h8000_0000, 64'h4000_0000, mulLat(32), 0, "mulh32");
    runOp(1'b0, CmdMulhsu, 1'b0, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 64'hFFFF_FFFF, mulLat(32), 0, "mulhsu32");
    runOp(1'b0, CmdMulhu,  1'b0, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 64'hFFFF_FFFE, mulLat(32), 0, "mulhu32");
    runOp(1'b0, CmdDiv,    1'b0, 64'd5,          64'd0,         64'hFFFF_FFFF, 0,  0, "divZero32");
    runOp(1'b0, CmdRem,    1'b0, 64'd5,          64'd0,         64'd5,         0,  0, "remZero32");
    runOp(1'b0, CmdDiv,    1'b0, 64'h8000_0000,  64'hFFFF_FFFF, 64'h8000_0000, 0,  0, "divOvf32");
    runOp(1'b0, CmdRem,    1'b0, 64'h8000_0000,  64'hFFFF_FFFF, 64'd0,         0,  0, "remOvf32");
    runOp(1'b0, CmdDiv,    1'b0, 64'hFFFF_FFF9,  64'd2,         64'hFFFF_FFFD, 32, 0, "divNeg32");
    runOp(1'b0, CmdRem,    1'b0, 64'hFFFF_FFF9,  64'd2,         64'hFFFF_FFFF, 32, 0, "remNeg32");
    runOp(1'b0, CmdDivu,   1'b0, 64'd100,        64'd7,         64'd14,        32, 0, "divu32");
    runOp(1'b0, CmdRemu,   1'b0, 64'hFFFF_FFFF,  64'd10,        64'd5,         32, 0, "remu32");
    runOp(1'b0, CmdMul,    1'b0, 64'h1_2345,     64'h10,        64'h12_3450, mulLat(32), 5, "stall32");

    // XLEN=64 ops, full width and W forms
    runOp(1'b1, CmdDiv,    1'b1, 64'h1_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32, 0, "divw64");
    runOp(1'b1, CmdMul,    1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, mulLat(64), 0, "mul64");
    runOp(1'b1, CmdMulhu,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFE, mulLat(64), 0, "mulhu64");
    runOp(1'b1, CmdMulh,   1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
          64'h4000_0000_0000_0000, mulLat(64), 0, "mulh64");
    runOp(1'b1, CmdMul,    1'b1, 64'hABCD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, mulLat(32), 0, "mulw64");
    runOp(1'b1, CmdRem,    1'b1, 64'h1234_5678_FFFF_FFF9, 64'h5_0000_0002,
          64'hFFFF_FFFF_FFFF_FFFF, 32, 0, "remw64");
    runOp(1'b1, CmdDivu,   1'b1, 64'd9, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, "divuwZero64");
    runOp(1'b1, CmdDiv,    1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, 0, "divwOvf64");
    runOp(1'b1, CmdRem,    1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64, 0, "rem64");

    // Flush a 64-bit Divu at cycle 10, then issue a fresh op straight away
    @(negedge clk);
    drive(1'b1, 1'b1, CmdDivu, 1'b0, 64'hFFFF_0000_1111_2222, 64'd3);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, CmdDivu, 1'b0, 64'd0, 64'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    if64.flush = 1'b1;
    @(posedge clk); #1;
    if64.flush = 1'b0;
    checkVal("flush_inReady", 64'(if64.inReady), 64'd1);
    checkVal("flush_outValid", 64'(if64.outValid), 64'd0);
    runOp(1'b1, CmdDivu, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1000, 64'h0001_2345_6789_ABCD, 64, 0, "divuAfterFlush");

    // Flush together with a request: the request is dropped
    @(negedge clk);
    drive(1'b1, 1'b1, CmdDivu, 1'b0, 64'd1, 64'd0);
    if64.flush = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, CmdDivu, 1'b0, 64'd0, 64'd0);
    if64.flush = 1'b0;
    checkVal("flushReq_inReady", 64'(if64.inReady), 64'd1);
    checkVal("flushReq_outValid", 64'(if64.outValid), 64'd0);

    // Reset pulsed mid-Run on the 32-bit unit
    @(negedge clk);
    drive(1'b0, 1'b1, CmdDiv, 1'b0, 64'hFFFF_FFF9, 64'd2);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, CmdDiv, 1'b0, 64'd0, 64'd0);
    repeat (5) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkVal("midRst_inReady32", 64'(if32.inReady), 64'd1);
    checkVal("midRst_outValid32", 64'(if32.outValid), 64'd0);
    checkVal("midRst_result32", {32'h0, if32.result}, 64'd0);
    checkVal("midRst_result64", if64.result, 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    runOp(1'b0, CmdDivu, 1'b0, 64'd1000, 64'd33, 64'd30, 32, 0, "divuAfterRst");

    repeat (3) @(posedge clk);
    checkVal("sbDrained32", 64'(sb32.size()), 64'd0);
    checkVal("sbDrained64", 64'(sb64.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
